// File: rtl/fault_response_checker.sv
// Bit-parallel fault-simulation response checker: sticky per-fault detection mask,
// saturating pattern count, serial popcount of detected faults. Define FRC_MISR_EN for the golden-stream MISR.
module fault_response_checker #(
    parameter int unsigned NF  = 32,
    parameter int unsigned PCW = 16,
    localparam int unsigned CW = $clog2(NF + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           golden,
    input  logic [NF-1:0]  faulty,
    input  logic           last,
    output logic [NF-1:0]  det_mask,
    output logic [CW-1:0]  det_count,
    output logic [PCW-1:0] pat_count,
    output logic           busy,
    output logic           done
`ifdef FRC_MISR_EN
    ,
    output logic [15:0]    signature
`endif
);

    localparam int unsigned IW = $clog2(NF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_n;
    logic          clear;
    logic          accept;
    logic          count_en;
    logic [IW-1:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        clear    = 1'b0;
        accept   = 1'b0;
        count_en = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    clear   = 1'b1;
                end
            end
            RUN: begin
                accept = in_valid & in_ready;
                if (accept && last) begin
                    state_n = COUNT;
                end
            end
            COUNT: begin
                count_en = 1'b1;
                if (idx == IW'(NF - 1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_n = RUN;
                    clear   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            det_mask  <= '0;
            det_count <= '0;
            pat_count <= '0;
            idx       <= '0;
        end else begin
            in_ready <= (state_n == RUN);
            busy     <= (state_n == RUN) || (state_n == COUNT);
            done     <= (state_n == DONE);
            if (clear) begin
                det_mask  <= '0;
                det_count <= '0;
                pat_count <= '0;
                idx       <= '0;
            end else if (accept) begin
                det_mask <= det_mask | (faulty ^ {NF{golden}});
                if (pat_count != {PCW{1'b1}}) begin
                    pat_count <= pat_count + PCW'(1);
                end
            end else if (count_en) begin
                det_count <= det_count + CW'(det_mask[idx]);
                idx       <= idx + IW'(1);
            end
        end
    end

`ifdef FRC_MISR_EN
    // CCITT-polynomial MISR over the golden bit of each accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            signature <= 16'h0000;
        end else if (clear) begin
            signature <= 16'h0000;
        end else if (accept) begin
            signature <= {signature[14:0], 1'b0}
                       ^ ((signature[15] ^ golden) ? 16'h1021 : 16'h0000);
        end
    end
`endif

endmodule

// File: tb/tb_fault_response_checker.sv
// Randomized self-checking bench for fault_response_checker against a behavioural model.
module tb_fault_response_checker;

    localparam int unsigned NF  = 4;
    localparam int unsigned PCW = 2;
    localparam int unsigned CW  = $clog2(NF + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           in_valid;
    logic           in_ready;
    logic           golden;
    logic [NF-1:0]  faulty;
    logic           last;
    logic [NF-1:0]  det_mask;
    logic [CW-1:0]  det_count;
    logic [PCW-1:0] pat_count;
    logic           busy;
    logic           done;
`ifdef FRC_MISR_EN
    logic [15:0]    signature;
`endif

    fault_response_checker #(.NF(NF), .PCW(PCW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .golden    (golden),
        .faulty    (faulty),
        .last      (last),
        .det_mask  (det_mask),
        .det_count (det_count),
        .pat_count (pat_count),
        .busy      (busy),
        .done      (done)
`ifdef FRC_MISR_EN
        ,
        .signature (signature)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: set of detected slots, number of accepted beats, MISR value.
    logic [NF-1:0] m_mask;
    int            m_pats;
    logic [15:0]   m_sig;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_pats();
        int sat = (1 << PCW) - 1;
        return (m_pats > sat) ? sat : m_pats;
    endfunction

    function automatic int popcount(input logic [NF-1:0] v);
        int n = 0;
        for (int i = 0; i < int'(NF); i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic check_results(input string tag);
        check({tag, "_mask"}, 32'(det_mask), 32'(m_mask));
        check({tag, "_pats"}, 32'(pat_count), 32'(exp_pats()));
`ifdef FRC_MISR_EN
        check({tag, "_sig"}, 32'(signature), 32'(m_sig));
`endif
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start  = 1'b0;
        m_mask = '0;
        m_pats = 0;
        m_sig  = 16'h0000;
        check("start_busy", 32'(busy), 32'd1);
        check("start_ready", 32'(in_ready), 32'd1);
        check("start_done", 32'(done), 32'd0);
        check_results("start");
    endtask

    task automatic beat(input logic v, input logic g, input logic [NF-1:0] f,
                        input logic l, input logic s);
        logic fb;
        in_valid = v;
        golden   = g;
        faulty   = f;
        last     = l;
        start    = s;
        tick();
        in_valid = 1'b0;
        last     = 1'b0;
        start    = 1'b0;
        if (v) begin
            for (int i = 0; i < int'(NF); i++)
                if (f[i] != g) m_mask[i] = 1'b1;
            m_pats++;
            fb    = m_sig[15] ^ g;
            m_sig = (m_sig << 1) ^ (fb ? 16'h1021 : 16'h0000);
        end
        if (!(v && l)) check("run_ready", 32'(in_ready), 32'd1);
        check_results("beat");
    endtask

    // Walk through COUNT with garbage on the inputs, then verify DONE results.
    task automatic finish_run(input string tag);
        for (int k = 0; k < int'(NF); k++) begin
            check({tag, "_cnt_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_cnt_busy"}, 32'(busy), 32'd1);
            check({tag, "_cnt_done"}, 32'(done), 32'd0);
            in_valid = 1'($urandom);
            golden   = 1'($urandom);
            faulty   = NF'($urandom);
            start    = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
        check({tag, "_done_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_dcount"}, 32'(det_count), 32'(popcount(m_mask)));
        check_results(tag);
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            faulty   = NF'($urandom);
            golden   = 1'($urandom);
            tick();
            check({tag, "_hold_done"}, 32'(done), 32'd1);
            check({tag, "_hold_dcount"}, 32'(det_count), 32'(popcount(m_mask)));
            check_results({tag, "_hold"});
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; golden = 1'b0; faulty = '0; last = 1'b0;
        m_mask = '0; m_pats = 0; m_sig = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_dcount", 32'(det_count), 32'd0);
        check_results("rst");

        // Beats in IDLE are ignored.
        in_valid = 1'b1; golden = 1'b0; faulty = 4'b1111; last = 1'b1;
        tick();
        in_valid = 1'b0; last = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check_results("idle");

        // Directed example run.
        do_start();
        beat(1'b1, 1'b0, 4'b0001, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 4'b1101, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        check("t1_mask_const", 32'(det_mask), 32'h3);
        check("t1_pats_const", 32'(pat_count), 32'd3);
        finish_run("t1");
        check("t1_dcount_const", 32'(det_count), 32'd2);

        // Valid toggling 1,0,1,1 from DONE.
        do_start();
        beat(1'b1, 1'b1, 4'b0111, 1'b0, 1'b0);
        beat(1'b0, 1'b0, 4'b1111, 1'b1, 1'b0);
        beat(1'b1, 1'b0, 4'b0100, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 4'b1111, 1'b1, 1'b0);
        check("t2_pats_const", 32'(pat_count), 32'd3);
        finish_run("t2");

        // Five beats saturate the 2-bit pattern counter; mask still covers all five.
        do_start();
        beat(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 4'b0111, 1'b1, 1'b0);
        check("t3_pats_const", 32'(pat_count), 32'd3);
        check("t3_mask_const", 32'(det_mask), 32'h8);
        finish_run("t3");

        // No differences and start pulses inside RUN.
        do_start();
        beat(1'b1, 1'b1, 4'b1111, 1'b0, 1'b1);
        beat(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
        beat(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        finish_run("t4");
        check("t4_dcount_const", 32'(det_count), 32'd0);

`ifdef FRC_MISR_EN
        do_start();
        beat(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
        check("misr_b1", 32'(signature), 32'h1021);
        beat(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
        check("misr_b2", 32'(signature), 32'h3063);
        beat(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        check("misr_b3", 32'(signature), 32'h60C6);
        finish_run("misr");
`endif

        // Reset in the middle of COUNT at index 2.
        do_start();
        beat(1'b1, 1'b0, 4'b1111, 1'b1, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_mask = '0; m_pats = 0; m_sig = 16'h0000;
        check("rstc_busy", 32'(busy), 32'd0);
        check("rstc_done", 32'(done), 32'd0);
        check("rstc_dcount", 32'(det_count), 32'd0);
        check_results("rstc");

        // Reset wins over a coincident start.
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        check("rst_start_ready", 32'(in_ready), 32'd0);

        // Randomized runs.
        for (int r = 0; r < 25; r++) begin
            int nb;
            do_start();
            nb = int'($urandom_range(1, 7));
            for (int b = 0; b < nb; b++) begin
                logic v;
                logic l;
                v = 1'($urandom);
                l = v ? 1'b0 : 1'($urandom);
                beat(v, 1'($urandom), NF'($urandom), l, 1'($urandom));
            end
            beat(1'b1, 1'($urandom), NF'($urandom), 1'b1, 1'($urandom));
            finish_run("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fault_response_checker.md
# fault_response_checker

Bit-parallel response checker for the parallel fault simulator. Each accepted beat carries one golden output bit and NF faulty-machine output bits from the circuit under test. The block accumulates a sticky per-fault detection mask and counts accepted patterns. After the last pattern it serially counts the detected faults and raises `done`. It sits downstream of the fault-injected circuit copies and is the consuming end of the stimulus/response stream.

## Interface
- `NF`, 32, number of fault slots simulated in parallel (≥2)
- `PCW`, 16, pattern counter width
- `CW`, `$clog2(NF+1)`, detected-count width (localparam)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a new run from IDLE or DONE
- `in_valid`  in  1  response beat valid
- `in_ready`  out  1  block can accept a beat
- `golden`  in  1  fault-free output for this pattern
- `faulty`  in  NF  per-fault output; bit i = fault slot i
- `last`  in  1  qualifies the final beat of the run
- `det_mask`  out  NF  sticky detection mask; bit i = 1 once slot i ever differed from golden
- `det_count`  out  CW  number of ones in `det_mask`; final only while `done`
- `pat_count`  out  PCW  accepted beats in this run, saturating
- `busy`  out  1  high in RUN and COUNT
- `done`  out  1  high in DONE
- `signature`  out  16  MISR of the golden stream (only with `FRC_MISR_EN`)

## Operation
- States: IDLE, RUN, COUNT, DONE. Reset state is IDLE.
- Reset values: all outputs 0, `det_mask` = 0, `signature` = 16'h0000.
- IDLE:
  - `start` → RUN; clears `det_mask`, `pat_count`, `det_count`, `signature`.
  - `in_valid` is ignored.
- RUN:
  - `in_ready` = 1.
  - Accept when `in_valid & in_ready`: `det_mask <= det_mask | (faulty ^ {NF{golden}})`.
  - On accept, `pat_count` increments and holds at 2^PCW−1.
  - Accept with `last` = 1 → COUNT.
  - `start` is ignored.
- COUNT:
  - `in_ready` = 0.
  - An index i runs from 0 to NF−1, one bit per cycle; `det_count += det_mask[i]`.
  - After i = NF−1 → DONE.
  - `start` is ignored.
- DONE:
  - `done` = 1; all results are held stable.
  - `start` → RUN with the same clears as from IDLE.
- `det_mask` changes only on accepted beats. It is never cleared except by `start` or `rst`.
- `rst` in any state, including mid-RUN or mid-COUNT, returns to IDLE with reset values on the next edge.

## Timing
- `start` sampled at edge T: `busy` and `in_ready` are high from T+1.
- Accepted beats update `det_mask` and `pat_count` at the accepting edge, visible the next cycle.
- Last beat accepted at edge L:
  - COUNT occupies cycles L+1 … L+NF.
  - `done` = 1 from L+NF+1.
  - `in_ready` is low from L+1.
- Back-to-back beats are accepted every cycle in RUN. There are no bubbles and no combinational path from `in_valid` to `in_ready`.
- `start` coinciding with `rst`: `rst` wins.

## Configuration
- `FRC_MISR_EN` defined:
  - Adds the `signature` port.
  - Per accepted beat: f = `signature[15]` ^ `golden`; `signature <= (signature << 1) ^ (f ? 16'h1021 : 16'h0000)`.
  - Cleared on `start` and `rst`; held in COUNT and DONE.
- Not defined: no `signature` port and no MISR logic. All other behaviour is identical.

## Test plan
- NF=4: reset, then `start`; beats (golden,faulty) = (0,4'b0001), (1,4'b1101), (0,4'b0000) with `last` on beat 3 → `det_mask` = 4'b0011, `pat_count` = 3, `det_count` = 2, `done` exactly 4 cycles after the `last` accept.
- `in_valid` toggling 1,0,1,1 in RUN → only valid cycles counted; `pat_count` = 3; `in_ready` stays 1 throughout RUN.
- PCW=2, 5 beats → `pat_count` saturates at 3; `det_mask` still ORs all 5 beats.
- `rst` asserted during COUNT at i = 2 → next cycle IDLE; `det_mask` = 0, `det_count` = 0, `busy` = 0, `done` = 0.
- From DONE, `start` → `det_mask`/`pat_count` cleared; second run with all faulty bits equal to golden → `det_count` = 0; `start` pulses during RUN are ignored.
- `FRC_MISR_EN`: golden stream 1,1,0 from cleared state → `signature` = 16'h1021 after beat 1, 16'h3063 after beat 2, 16'h60C6 after beat 3.
